// File: rtl/rotary_detent_value_pkg.sv
// Shared types and constants for the rotary detent value block.
package rotary_pkg;

  localparam int ENC_COUNT_W = 8;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } rot_state_e;

endpackage

// File: rtl/rotary_detent_value_if.sv
// Signal bundle between the encoder/button front end (master) and the
// detent value block (slave).
interface rotary_detent_value_if #(
  parameter int WIDTH = 8
);

  // No handshake: enc_count and button are level signals sampled every clock;
  // value/at_limit are levels and changed is a single-cycle strobe.
  logic [rotary_pkg::ENC_COUNT_W-1:0] enc_count;
  logic                               button;
  logic [WIDTH-1:0]                   value;
  logic                               changed;
  logic                               at_limit;

  modport master (
    output enc_count,
    output button,
    input  value,
    input  changed,
    input  at_limit
  );

  modport slave (
    input  enc_count,
    input  button,
    output value,
    output changed,
    output at_limit
  );

endinterface

// File: rtl/rotary_detent_value_detent_accumulator.sv
// Turns the wrapping encoder count into detent up/down events, keeping the
// sub-detent residual between cycles.
module detent_accumulator
  import rotary_pkg::*;
#(
  parameter int COUNTS_PER_DETENT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run_i,
  input  logic                   clear_i,
  input  logic [ENC_COUNT_W-1:0] enc_count_i,
  output logic                   det_up_o,
  output logic                   det_down_o
);

  localparam logic signed [ENC_COUNT_W:0] CPD = (ENC_COUNT_W+1)'(COUNTS_PER_DETENT);

  logic [ENC_COUNT_W-1:0]        enc_prev_q;
  logic signed [ENC_COUNT_W:0]   acc_q, acc_d;
  logic signed [ENC_COUNT_W-1:0] delta;
  logic signed [ENC_COUNT_W:0]   sum;

  // Modular subtraction then signed reinterpretation gives correct wrap deltas.
  always_comb begin
    delta      = $signed(enc_count_i - enc_prev_q);
    sum        = acc_q + $signed({delta[ENC_COUNT_W-1], delta});
    det_up_o   = 1'b0;
    det_down_o = 1'b0;
    acc_d      = acc_q;
    if (run_i) begin
      if (sum >= CPD) begin
        det_up_o = 1'b1;
        acc_d    = sum - CPD;
      end else if (sum <= -CPD) begin
        det_down_o = 1'b1;
        acc_d      = sum + CPD;
      end else begin
        acc_d = sum;
      end
      if (clear_i) begin
        acc_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_prev_q <= '0;
      acc_q      <= '0;
    end else begin
      enc_prev_q <= enc_count_i;
      acc_q      <= acc_d;
    end
  end

endmodule

// File: rtl/rotary_detent_value.sv
// Bounded, saturating user value driven by encoder detents; button restores
// the default. Optional acceleration under ROTARY_ACCEL_EN.
module rotary_detent_value
  import rotary_pkg::*;
#(
  parameter int WIDTH             = 8,
  parameter int MIN_VAL           = 0,
  parameter int MAX_VAL           = 15,
  parameter int INIT_VAL          = 0,
  parameter int COUNTS_PER_DETENT = 4,
  parameter int ACCEL_WINDOW      = 2000000,
  parameter int ACCEL_STEP        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rotary_detent_value_if.slave  bus,
  output rot_state_e            dbg_state_o
);

  localparam logic [WIDTH:0]   MIN_EXT       = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MAX_EXT       = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] INIT_V        = WIDTH'(INIT_VAL);
  localparam logic             INIT_AT_LIMIT = (INIT_VAL == MIN_VAL) || (INIT_VAL == MAX_VAL);

  if (COUNTS_PER_DETENT < 1 || COUNTS_PER_DETENT > 64 || MIN_VAL > INIT_VAL ||
      INIT_VAL > MAX_VAL || MAX_VAL >= (1 << WIDTH) || ACCEL_STEP < 1 ||
      ACCEL_WINDOW < 1) begin : g_bad_params
    $error("rotary_detent_value: illegal parameter combination");
  end

  rot_state_e       state_q, state_d;
  logic             btn_prev_q;
  logic [WIDTH-1:0] value_q, value_d;
  logic             changed_q, changed_d;
  logic             at_limit_q, at_limit_d;
  logic             run, btn_fall, det_up, det_down;
  logic [WIDTH:0]   step, value_ext, up_sum, dn_floor, dn_diff;

  detent_accumulator #(
    .COUNTS_PER_DETENT (COUNTS_PER_DETENT)
  ) u_acc (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (run),
    .clear_i     (btn_fall),
    .enc_count_i (bus.enc_count),
    .det_up_o    (det_up),
    .det_down_o  (det_down)
  );

  // SYNC lasts one cycle after reset so stale counts never produce a detent.
  always_comb begin
    state_d = RUN;
    case (state_q)
      SYNC:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = SYNC;
    endcase
  end

  assign run      = (state_q == RUN);
  assign btn_fall = run && btn_prev_q && !bus.button;

`ifdef ROTARY_ACCEL_EN
  localparam int             ACW      = $clog2(ACCEL_WINDOW + 1);
  localparam logic [ACW-1:0] WINDOW_C = ACW'(ACCEL_WINDOW);

  logic [ACW-1:0] acnt_q, acnt_d;
  logic           dir_up_q, dir_up_d;

  always_comb begin
    acnt_d   = acnt_q;
    dir_up_d = dir_up_q;
    step     = (WIDTH+1)'(1);
    if ((acnt_q < WINDOW_C) && ((det_up && dir_up_q) || (det_down && !dir_up_q))) begin
      step = (WIDTH+1)'(ACCEL_STEP);
    end
    if (btn_fall) begin
      acnt_d = WINDOW_C;
    end else if (det_up || det_down) begin
      acnt_d   = '0;
      dir_up_d = det_up;
    end else if (acnt_q < WINDOW_C) begin
      acnt_d = acnt_q + ACW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acnt_q   <= WINDOW_C;
      dir_up_q <= 1'b1;
    end else begin
      acnt_q   <= acnt_d;
      dir_up_q <= dir_up_d;
    end
  end
`else
  assign step = (WIDTH+1)'(1);
`endif

  // Saturation is done one bit wider so the bound test cannot wrap.
  always_comb begin
    value_ext = {1'b0, value_q};
    up_sum    = value_ext + step;
    dn_floor  = MIN_EXT + step;
    dn_diff   = value_ext - step;
    value_d   = value_q;
    if (btn_fall) begin
      value_d = INIT_V;
    end else if (det_up) begin
      value_d = (up_sum > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : up_sum[WIDTH-1:0];
    end else if (det_down) begin
      value_d = (value_ext < dn_floor) ? MIN_EXT[WIDTH-1:0] : dn_diff[WIDTH-1:0];
    end
    changed_d  = (value_d != value_q);
    at_limit_d = ({1'b0, value_d} == MIN_EXT) || ({1'b0, value_d} == MAX_EXT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SYNC;
      btn_prev_q <= 1'b1;
      value_q    <= INIT_V;
      changed_q  <= 1'b0;
      at_limit_q <= INIT_AT_LIMIT;
    end else begin
      state_q    <= state_d;
      btn_prev_q <= bus.button;
      value_q    <= value_d;
      changed_q  <= changed_d;
      at_limit_q <= at_limit_d;
    end
  end

  assign bus.value    = value_q;
  assign bus.changed  = changed_q;
  assign bus.at_limit = at_limit_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_rotary_detent_value.sv
// Bench for rotary_detent_value: directed encoder/button vectors, a
// per-cycle model comparison and hand-computed checkpoints.
module tb_rotary_detent_value;
  import rotary_pkg::*;

  localparam int WIDTH    = 8;
  localparam int MIN_VAL  = 0;
  localparam int MAX_VAL  = 15;
  localparam int INIT_VAL = 0;
  localparam int CPD      = 4;
  localparam int TB_WIN   = 200;
  localparam int A_STEP   = 4;
`ifdef ROTARY_ACCEL_EN
  localparam int GAP        = TB_WIN + 2;
  localparam int EXCESS_EXP = 5;
`else
  localparam int GAP        = 10;
  localparam int EXCESS_EXP = 2;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rotary_detent_value_if #(.WIDTH(WIDTH)) bus ();
  rot_state_e dbg_state;

  rotary_detent_value #(
    .WIDTH             (WIDTH),
    .MIN_VAL           (MIN_VAL),
    .MAX_VAL           (MAX_VAL),
    .INIT_VAL          (INIT_VAL),
    .COUNTS_PER_DETENT (CPD),
    .ACCEL_WINDOW      (TB_WIN),
    .ACCEL_STEP        (A_STEP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_cmp    = 0;
  int n_bad    = 0;
  int n_pulses = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model: plain integer arithmetic following the block's rules
  int m_val = INIT_VAL, m_res = 0, m_prev = 0, m_cnt = TB_WIN;
  bit m_sync = 0, m_btn_prev = 1, m_changed = 0, m_dirup = 1;
  bit m_limit = (INIT_VAL == MIN_VAL) || (INIT_VAL == MAX_VAL);

  always @(posedge clk or negedge rst_n) begin
    int d, s, dir, step, nv;
    bit fall;
    if (!rst_n) begin
      m_sync = 0; m_val = INIT_VAL; m_res = 0; m_changed = 0; m_cnt = TB_WIN;
      m_limit = (INIT_VAL == MIN_VAL) || (INIT_VAL == MAX_VAL);
    end else if (!m_sync) begin
      m_sync = 1; m_prev = int'(bus.enc_count); m_btn_prev = bus.button; m_changed = 0;
    end else begin
      d = (int'(bus.enc_count) - m_prev) & 255;
      if (d > 127) d -= 256;
      m_prev = int'(bus.enc_count);
      s = m_res + d;
      dir = 0;
      if (s >= CPD) begin dir = 1; s -= CPD; end
      else if (s <= -CPD) begin dir = -1; s += CPD; end
      fall = m_btn_prev && !bus.button;
      m_btn_prev = bus.button;
      step = 1;
`ifdef ROTARY_ACCEL_EN
      if (fall) m_cnt = TB_WIN;
      else if (dir != 0) begin
        if (m_cnt < TB_WIN && ((dir == 1) == m_dirup)) step = A_STEP;
        m_dirup = (dir == 1);
        m_cnt = 0;
      end else if (m_cnt < TB_WIN) m_cnt++;
`endif
      nv = m_val;
      if (fall) begin nv = INIT_VAL; s = 0; end
      else if (dir == 1) nv = (m_val + step > MAX_VAL) ? MAX_VAL : m_val + step;
      else if (dir == -1) nv = (m_val - step < MIN_VAL) ? MIN_VAL : m_val - step;
      m_res = s;
      m_changed = (nv != m_val);
      m_val = nv;
      m_limit = (nv == MIN_VAL) || (nv == MAX_VAL);
    end
  end

  // scoreboard: compare every cycle
  always @(negedge clk) begin
    check("value", int'(bus.value), m_val);
    check("changed", int'(bus.changed), int'(m_changed));
    check("at_limit", int'(bus.at_limit), int'(m_limit));
    check("state", int'(dbg_state), int'(m_sync));
    if (bus.changed) n_pulses++;
  end

  // driver tasks
  task automatic do_reset(input int enc);
    @(negedge clk);
    rst_n = 1'b0;
    bus.enc_count = 8'(enc);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic move(input int delta);
    @(negedge clk);
    bus.enc_count = bus.enc_count + 8'(delta);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.enc_count = 8'd37;
    bus.button    = 1'b1;
    rst_n         = 1'b0;
    idle(5);
    check("rst_value", int'(bus.value), 0);
    check("rst_changed", int'(bus.changed), 0);
    check("rst_at_limit", int'(bus.at_limit), 1);
    rst_n = 1'b1;
    n_pulses = 0;
    idle(20);
    check("post_rst_no_detent", n_pulses, 0);
    check("post_rst_value", int'(bus.value), 0);

    // single-step counts 0..4
    do_reset(0);
    n_pulses = 0;
    for (int k = 1; k <= 4; k++) begin
      move(1);
      if (k < 4) check("step_hold", int'(bus.value), 0);
      else begin
        check("step_detent", int'(bus.value), 1);
        check("step_pulse", int'(bus.changed), 1);
      end
      idle(8);
    end
    check("step_pulse_once", n_pulses, 1);

    // wrap-around both directions
    do_reset(254);
    for (int k = 0; k < 4; k++) begin move(1); idle(GAP); end
    check("wrap_up", int'(bus.value), 1);
    for (int k = 0; k < 4; k++) begin move(-1); idle(GAP); end
    check("wrap_down", int'(bus.value), 0);

    // saturation at MAX_VAL
    for (int k = 0; k < 15; k++) begin move(4); idle(GAP); end
    check("reach_max", int'(bus.value), 15);
    n_pulses = 0;
    for (int k = 0; k < 3; k++) begin move(4); idle(GAP); end
    check("sat_value", int'(bus.value), 15);
    check("sat_at_limit", int'(bus.at_limit), 1);
    check("sat_no_pulse", n_pulses, 0);

    // down to 7, then button together with an up detent
    for (int k = 0; k < 8; k++) begin move(-4); idle(GAP); end
    check("down_to_7", int'(bus.value), 7);
    check("mid_not_limit", int'(bus.at_limit), 0);
    n_pulses = 0;
    @(negedge clk);
    bus.enc_count = bus.enc_count + 8'd4;
    bus.button    = 1'b0;
    @(negedge clk);
    check("btn_value", int'(bus.value), 0);
    check("btn_pulse", int'(bus.changed), 1);
    check("btn_model_res", m_res, 0);
    bus.button = 1'b1;
    idle(GAP);
    check("btn_pulse_once", n_pulses, 1);

    // excess counts carry over to a second detent
    move(10);
    check("excess_first", int'(bus.value), 1);
    idle(GAP);
    check("excess_second", int'(bus.value), EXCESS_EXP);

    // saturation at MIN_VAL, then button while already at INIT_VAL
    for (int k = 0; k < 7; k++) begin move(-4); idle(GAP); end
    check("min_value", int'(bus.value), 0);
    check("min_at_limit", int'(bus.at_limit), 1);
    n_pulses = 0;
    @(negedge clk);
    bus.button = 1'b0;
    idle(3);
    bus.button = 1'b1;
    idle(3);
    check("btn_at_init_no_pulse", n_pulses, 0);

    // reset mid-operation with a count offset at deassertion
    move(2);
    @(negedge clk);
    rst_n = 1'b0;
    bus.enc_count = 8'd123;
    @(negedge clk);
    rst_n = 1'b1;
    n_pulses = 0;
    idle(10);
    check("midop_rst_quiet", n_pulses, 0);

`ifdef ROTARY_ACCEL_EN
    do_reset(0);
    move(4);
    check("accel_first", int'(bus.value), 1);
    idle(100);
    move(4);
    check("accel_second", int'(bus.value), 5);
    idle(TB_WIN + 1);
    move(4);
    check("accel_third", int'(bus.value), 6);
    idle(5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rotary_detent_value.md
# rotary_detent_value

Converts the wrapping 8-bit quadrature count from the rotary encoder stage into a bounded, saturating user value, one step per mechanical detent. The pushbutton restores a default. Sits directly downstream of the encoder decoder and drives the LED/pin display logic in `top`. Exposes a one-cycle change strobe so later consumers can react to edits without polling.

## Interface
- `WIDTH`, 8: width of `value`.
- `MIN_VAL`, 0: lower saturation bound (unsigned).
- `MAX_VAL`, 15: upper saturation bound; requires MIN_VAL ≤ INIT_VAL ≤ MAX_VAL < 2^WIDTH.
- `INIT_VAL`, 0: value after reset and after a button press.
- `COUNTS_PER_DETENT`, 4: encoder counts per detent; must be in 1..64.
- `ACCEL_WINDOW`, 2000000: cycle window for acceleration (125 ms at 16 MHz); used only with `ROTARY_ACCEL_EN`.
- `ACCEL_STEP`, 4: step size when accelerated; used only with `ROTARY_ACCEL_EN`.
- `clk`  in  1: system clock (16 MHz `CLK`).
- `rst_n`  in  1: asynchronous, active-low reset.
- `enc_count`  in  8: wrapping count from the encoder stage, synchronous to `clk`.
- `button`  in  1: debounced pushbutton, idle high, pressed low.
- `value`  out  WIDTH: current bounded value.
- `changed`  out  1: one-cycle pulse whenever `value` changes.
- `at_limit`  out  1: high while `value` == MIN_VAL or `value` == MAX_VAL.

## Operation
- FSM states:
  - SYNC: entered on reset. Captures `enc_count` into `enc_prev` and `button` into `btn_prev`. Generates no delta, detent or button event. Moves unconditionally to RUN after one cycle.
  - RUN: normal operation; leaves only on reset.
- Delta: `delta = enc_count - enc_prev`, computed mod 256 and interpreted as signed 8-bit (−128..127). `enc_prev <= enc_count` every RUN cycle.
- Residual accumulator `acc`, signed, 9 bits:
  - `sum = acc + delta`.
  - If `sum ≥ COUNTS_PER_DETENT`: detent up, `acc <= sum − COUNTS_PER_DETENT`.
  - Else if `sum ≤ −COUNTS_PER_DETENT`: detent down, `acc <= sum + COUNTS_PER_DETENT`.
  - Otherwise `acc <= sum`.
  - At most one detent per cycle; any excess stays in `acc`.
- Value update, computed in WIDTH+1 bits:
  - Up: `value <= min(value + step, MAX_VAL)`.
  - Down: `value <= max(value − step, MIN_VAL)`.
  - Never wraps. `step` = 1 unless accelerated.
- Button: a falling edge (`btn_prev`=1, `button`=0) sets `value <= INIT_VAL` and `acc <= 0`. It overrides any detent in the same cycle.
- `changed` is registered and high for exactly one cycle iff `value`'s next state differs from its current state. A detent into a saturated bound, or a button press while already at INIT_VAL, produces no pulse.
- `at_limit` is registered and derived from the next state of `value`.

## Timing
- Reset values: `value`=INIT_VAL, `changed`=0, `at_limit`=(INIT_VAL==MIN_VAL || INIT_VAL==MAX_VAL), `acc`=0, state=SYNC, accel counter saturated (not accelerated).
- Latency: an `enc_count` change sampled at edge N that completes a detent updates `value`, `changed` and `at_limit` at edge N+1.
- A button edge sampled at edge N takes effect at edge N+1.
- Wrap-around: 255→0 gives delta +1; 0→255 gives delta −1.
- Reset mid-operation: all state clears immediately (asynchronous). The first cycle after deassertion is SYNC, so a count offset present at deassertion yields no spurious detent.

## Configuration
- `ROTARY_ACCEL_EN` defined:
  - A cycle counter saturates at ACCEL_WINDOW and clears on every detent.
  - A detent uses `step`=ACCEL_STEP when the counter < ACCEL_WINDOW and its direction matches the previous detent; otherwise `step`=1.
  - A button press saturates the counter.
- `ROTARY_ACCEL_EN` undefined: `step` is always 1, and the counter and direction register are not built.

## Structure
- Package `rotary_pkg`: the FSM state enum (SYNC, RUN) and the shared constant `ENC_COUNT_W`=8.
- Sub-module `detent_accumulator`: delta computation, `enc_prev`, `acc`, and the registered-free `det_up`/`det_down` outputs.
- The top of the block holds the FSM, button edge detection, saturation logic and the acceleration logic.

## Test plan
- Reset: hold `rst_n`=0 with `enc_count`=37 → `value`=0, `changed`=0, `at_limit`=1. Release → no detent in the following 20 cycles.
- Step `enc_count` 0→1→2→3→4, one step every 10 cycles → `value` stays 0 through count 3, becomes 1 one cycle after count 4, and `changed` pulses exactly once.
- Wrap: `enc_count` 254→255→0→1→2 → one detent up (`value` 0→1). Reverse 2→1→0→255→254 → `value` returns to 0.
- Saturation: from `value`=15 apply 3 further up detents → `value` stays 15, `at_limit`=1, no `changed` pulse.
- Button: falling edge of `button` in the same cycle as an up detent at `value`=7 → `value`=0, `acc`=0, one `changed` pulse.
- With `ROTARY_ACCEL_EN`: two up detents 100 cycles apart → `value` 0→1→5. A third up detent after ACCEL_WINDOW+1 idle cycles → `value`=6.
